program_sequencer: RTL and testbench

- Control end of the 4-bit datapath: fetches 8-bit instructions from program memory, holds the instruction register, and decodes it into the computational unit's control inputs (nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel).
- Consumes the datapath's r_eq_0 status for conditional jumps.
- Sits between program memory and the computational unit. Runs one instruction per 3-cycle FETCH/LOAD_IR/EXEC loop.

---
 rtl/program_sequencer_pkg.sv | 76 +++++++
 rtl/seq_instr_decoder.sv | 66 ++++++
 rtl/program_sequencer.sv | 79 +++++++
 tb/tb_program_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer.
// State encoding, opcode fields, source/enable codes and the control bundle.
package program_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LOAD_IR = 2'd1,
        EXEC    = 2'd2
    } state_t;

    // Opcode prefixes, matched against the top bits of ir
    localparam logic       OP_LDI = 1'b0;     // ir[7]
    localparam logic [1:0] OP_MOV = 2'b10;    // ir[7:6]
    localparam logic [2:0] OP_ALU = 3'b110;   // ir[7:5]
    localparam logic [3:0] OP_JMP = 4'b1110;  // ir[7:4]
    localparam logic [3:0] OP_JNZ = 4'b1111;  // ir[7:4]

    // Data bus source codes; 0..7 follow the move source field directly
    localparam logic [3:0] SRC_DM    = 4'h7;
    localparam logic [3:0] SRC_PM    = 4'h8;
    localparam logic [3:0] SRC_IPINS = 4'h9;
    localparam logic [3:0] SRC_ZERO  = 4'hA;

    // reg_en bit positions
    localparam int EN_X0 = 0;
    localparam int EN_X1 = 1;
    localparam int EN_Y0 = 2;
    localparam int EN_Y1 = 3;
    localparam int EN_R  = 4;
    localparam int EN_M  = 5;
    localparam int EN_I  = 6;
    localparam int EN_DM = 7;
    localparam int EN_O  = 8;

    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    typedef struct packed {
        logic [3:0] source_sel;
        logic [8:0] reg_en;
        logic       i_sel;
        logic       x_sel;
        logic       y_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        source_sel: SRC_ZERO,
        reg_en:     9'h000,
        i_sel:      1'b0,
        x_sel:      1'b0,
        y_sel:      1'b0
    };

    // Enables for a destination code. A dm write also post-increments i.
    function automatic ctrl_t dest_ctrl(input logic [2:0] ddd);
        ctrl_t c;
        c = CTRL_IDLE;
        case (ddd)
            3'd0: c.reg_en[EN_X0] = 1'b1;
            3'd1: c.reg_en[EN_X1] = 1'b1;
            3'd2: c.reg_en[EN_Y0] = 1'b1;
            3'd3: c.reg_en[EN_Y1] = 1'b1;
            3'd4: c.reg_en[EN_O]  = 1'b1;
            3'd5: c.reg_en[EN_M]  = 1'b1;
            3'd6: c.reg_en[EN_I]  = 1'b1;
            3'd7: begin
                c.reg_en[EN_DM] = 1'b1;
                c.reg_en[EN_I]  = 1'b1;
                c.i_sel         = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_instr_decoder.sv
// Combinational instruction decoder: ir -> datapath controls and jump decision.
// Ports: ir, exec (state is EXEC), r_eq_0 in; ctrl bundle, jump_taken out.
module seq_instr_decoder
    import program_sequencer_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       exec,
    input  logic       r_eq_0,
    output ctrl_t      ctrl,
    output logic       jump_taken
);

    logic       is_ldi;
    logic       is_mov;
    logic       is_alu;
    logic       is_jmp;
    logic       is_jnz;
    logic [2:0] mv_dst;
    logic [2:0] mv_src;

    assign is_ldi = (ir[7] == OP_LDI);
    assign is_mov = (ir[7:6] == OP_MOV);
    assign is_alu = (ir[7:5] == OP_ALU);
    assign is_jmp = (ir[7:4] == OP_JMP);
    assign is_jnz = (ir[7:4] == OP_JNZ);
    assign mv_dst = ir[5:3];
    assign mv_src = ir[2:0];

    always_comb begin
        ctrl       = CTRL_IDLE;
        jump_taken = 1'b0;
        if (exec) begin
            unique case (1'b1)
                is_ldi: begin
                    ctrl            = dest_ctrl(ir[6:4]);
                    ctrl.source_sel = SRC_PM;
                end
                is_mov: begin
                    ctrl = dest_ctrl(mv_dst);
                    // Self-move reads the external i_pins instead
                    if (mv_src == mv_dst)
                        ctrl.source_sel = SRC_IPINS;
                    else
                        ctrl.source_sel = {1'b0, mv_src};
                    // dm read post-increments i unless i is the target
                    if (mv_src == 3'd7 && mv_dst != DST_I) begin
                        ctrl.reg_en[EN_I] = 1'b1;
                        ctrl.i_sel        = 1'b1;
                    end
                end
                is_alu: begin
                    ctrl.reg_en[EN_R] = 1'b1;
                    ctrl.x_sel        = ir[4];
                    ctrl.y_sel        = ir[3];
                end
                is_jmp: jump_taken = 1'b1;
                is_jnz: jump_taken = ~r_eq_0;
                default: begin
                    ctrl       = CTRL_IDLE;
                    jump_taken = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: FETCH/LOAD_IR/EXEC loop holding pc, ir and state.
// Ports: clk, sync_reset (async high), hold, pm_data, r_eq_0 in;
//        pm_addr, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel out.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            hold,
    input  logic [7:0]      pm_data,
    input  logic            r_eq_0,
    output logic [PC_W-1:0] pm_addr,
    output logic [7:0]      ir,
    output logic [3:0]      nibble_ir,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel
);

    localparam logic [PC_W-1:0] RV = PC_W'(RESET_VECTOR);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
    logic            jump_taken;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (!hold) state_nxt = LOAD_IR;
            LOAD_IR: state_nxt = EXEC;
            EXEC:    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Jump target keeps the page of the already-incremented pc
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            pc <= RV;
            ir <= 8'h00;
        end else if (state == LOAD_IR) begin
            ir <= pm_data;
            pc <= pc + PC_W'(1);
        end else if (state == EXEC && jump_taken) begin
            pc <= {pc[PC_W-1:4], ir[3:0]};
        end
    end

    seq_instr_decoder u_dec (
        .ir         (ir),
        .exec       (state == EXEC),
        .r_eq_0     (r_eq_0),
        .ctrl       (ctrl),
        .jump_taken (jump_taken)
    );

    assign pm_addr    = pc;
    assign nibble_ir  = ir[3:0];
    assign source_sel = ctrl.source_sel;
    assign reg_en     = ctrl.reg_en;
    assign i_sel      = ctrl.i_sel;
    assign x_sel      = ctrl.x_sel;
    assign y_sel      = ctrl.y_sel;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer.
// Scoreboard of predicted EXEC controls and next fetch address.
module tb_program_sequencer;

    typedef struct {
        logic [7:0] ir;
        logic [3:0] src;
        logic [8:0] en;
        logic       isel;
        logic       x;
        logic       y;
        int         next;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       hold = 1'b0;
    logic [7:0] pm_data;
    logic       r_eq_0 = 1'b0;
    logic [7:0] pm_addr;
    logic [7:0] ir;
    logic [3:0] nibble_ir;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;

    logic [7:0] pm [0:255];
    exp_t       sb [$];
    int         m_pc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign pm_data = pm[pm_addr];

    program_sequencer #(.PC_W(8), .RESET_VECTOR(0)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .hold       (hold),
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_addr    (pm_addr),
        .ir         (ir),
        .nibble_ir  (nibble_ir),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h pc=%0h", tag, got, exp, m_pc);
        end
    endtask

    function automatic logic [9:0] dest(input logic [2:0] d);
        // {i_sel, reg_en}
        case (d)
            3'd0: return {1'b0, 9'h001};
            3'd1: return {1'b0, 9'h002};
            3'd2: return {1'b0, 9'h004};
            3'd3: return {1'b0, 9'h008};
            3'd4: return {1'b0, 9'h100};
            3'd5: return {1'b0, 9'h020};
            3'd6: return {1'b0, 9'h040};
            default: return {1'b1, 9'h0C0};
        endcase
    endfunction

    function automatic exp_t predict(input logic [7:0] i, input logic f,
                                     input int pc);
        exp_t       e;
        logic [2:0] d;
        logic [2:0] s;
        e.ir   = i;
        e.src  = 4'hA;
        e.en   = 9'h000;
        e.isel = 1'b0;
        e.x    = 1'b0;
        e.y    = 1'b0;
        e.next = (pc + 1) % 256;
        if (i[7] == 1'b0) begin
            e.src = 4'h8;
            {e.isel, e.en} = dest(i[6:4]);
        end else if (i[7:6] == 2'b10) begin
            d = i[5:3];
            s = i[2:0];
            e.src = (s == d) ? 4'h9 : {1'b0, s};
            {e.isel, e.en} = dest(d);
            if (s == 3'd7 && d != 3'd6) begin
                e.en   = e.en | 9'h040;
                e.isel = 1'b1;
            end
        end else if (i[7:5] == 3'b110) begin
            e.en = 9'h010;
            e.x  = i[4];
            e.y  = i[3];
        end else if (i[4] == 1'b0 || f == 1'b0) begin
            e.next = (((pc + 1) % 256) & 'hF0) | int'(i[3:0]);
        end
        return e;
    endfunction

    task automatic do_reset();
        sync_reset = 1'b1;
        #1;
        chk("rst_en", 32'(reg_en), 0);
        chk("rst_src", 32'(source_sel), 32'hA);
        @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(pm_addr), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_sel", 32'({i_sel, x_sel, y_sel}), 0);
        sync_reset = 1'b0;
        m_pc = 0;
    endtask

    // Entered and left at a negedge during FETCH
    task automatic do_instr(input logic [7:0] i, input logic f);
        exp_t e;
        pm[m_pc] = i;
        r_eq_0   = f;
        hold     = 1'b0;
        sb.push_back(predict(i, f, m_pc));
        chk("f_addr", 32'(pm_addr), 32'(m_pc));
        chk("f_en", 32'(reg_en), 0);
        @(posedge clk);
        @(negedge clk);
        chk("l_en", 32'(reg_en), 0);
        chk("l_src", 32'(source_sel), 32'hA);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("x_ir", 32'(ir), 32'(e.ir));
        chk("x_nib", 32'(nibble_ir), 32'(e.ir[3:0]));
        chk("x_src", 32'(source_sel), 32'(e.src));
        chk("x_en", 32'(reg_en), 32'(e.en));
        chk("x_isel", 32'(i_sel), 32'(e.isel));
        chk("x_xsel", 32'(x_sel), 32'(e.x));
        chk("x_ysel", 32'(y_sel), 32'(e.y));
        @(posedge clk);
        @(negedge clk);
        chk("n_addr", 32'(pm_addr), 32'(e.next));
        m_pc = e.next;
    endtask

    task automatic hold_cycles(input int n);
        hold = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("h_addr", 32'(pm_addr), 32'(m_pc));
            chk("h_en", 32'(reg_en), 0);
        end
        hold = 1'b0;
    endtask

    task automatic reset_in_exec(input logic [7:0] i);
        exp_t e;
        pm[m_pc] = i;
        hold     = 1'b0;
        e = predict(i, 1'b0, m_pc);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("re_pre_en", 32'(reg_en), 32'(e.en));
        sync_reset = 1'b1;
        #1;
        chk("re_en", 32'(reg_en), 0);
        chk("re_src", 32'(source_sel), 32'hA);
        chk("re_addr", 32'(pm_addr), 0);
        @(negedge clk);
        sync_reset = 1'b0;
        m_pc = 0;
    endtask

    task automatic climb(input int target);
        int guard;
        logic [7:0] v;
        guard = 0;
        while (m_pc != target && guard < 300) begin
            v = 8'($urandom_range(0, 8'hDF));
            do_instr(v, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("climb", 32'(m_pc), 32'(target));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) pm[a] = 8'h00;
        @(negedge clk);
        do_reset();
        do_instr(8'h07, 1'b0);
        hold_cycles(3);
        do_instr(8'h8F, 1'b0);
        do_instr(8'hA4, 1'b0);
        do_instr(8'hD2, 1'b1);
        do_instr(8'hBF, 1'b0);
        do_instr(8'hB7, 1'b0);
        climb(8'h1F);
        do_instr(8'hF3, 1'b0);
        do_instr(8'hE7, 1'b1);
        reset_in_exec(8'h17);
        climb(8'h1F);
        do_instr(8'hF3, 1'b1);
        climb(8'hFF);
        do_instr(8'h35, 1'b0);
        do_instr(8'hE9, 1'b0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
